// File: rtl/xbar_oneout_rr_arbiter_pkg.sv
// Shared types and helpers for the single-output crossbar round-robin arbiter.
package xbar_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    GRANT  = 2'd2
  } arb_state_e;

  // Widest control word the helper can build.
  localparam int unsigned CTRL_W_MAX = 256;

  // Places the input index in the top clog2(n_inputs) bits of a ctrl_w-bit word.
  function automatic logic [CTRL_W_MAX-1:0] build_control(input int unsigned idx,
                                                          input int unsigned ctrl_w,
                                                          input int unsigned n_inputs);
    int unsigned idx_w;
    idx_w = $clog2(n_inputs);
    return CTRL_W_MAX'(idx) << (ctrl_w - idx_w);
  endfunction

endpackage

// File: rtl/xbar_oneout_rr_arbiter_if.sv
// Request/transfer/control bundle between the arbiter and its crossbar output.
interface xbar_oneout_rr_arbiter_if #(
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 32
);
  localparam int unsigned IDX_W = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0]          req;
  logic                         xfer;
  logic                         sink_rdy;
  logic                         xbar_send_rdy;
  logic [CONTROL_BIT_WIDTH-1:0] control;
  logic                         control_val;
  logic                         control_rdy;
  logic [IDX_W-1:0]             grant_idx;
  logic                         grant_active;

  modport master (
    input  req, xfer, sink_rdy, control_rdy,
    output xbar_send_rdy, control, control_val, grant_idx, grant_active
  );

  modport slave (
    output req, xfer, sink_rdy, control_rdy,
    input  xbar_send_rdy, control, control_val, grant_idx, grant_active
  );

endinterface

// File: rtl/xbar_oneout_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned N_INPUTS = 2
) (
  input  logic [N_INPUTS-1:0]         req,
  input  logic [$clog2(N_INPUTS)-1:0] ptr,
  output logic [$clog2(N_INPUTS)-1:0] idx,
  output logic                        valid
);
  localparam int unsigned IDX_W = $clog2(N_INPUTS);

  // Scan from ptr upward modulo N_INPUTS, keeping the first hit.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_INPUTS) cand = cand - N_INPUTS;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/xbar_oneout_rr_arbiter.sv
// Round-robin scheduler for one crossbar output: arbitrates, programs the select,
// then holds the grant for up to MAX_BURST transfers.
// Optional macro XBAR_ARB_STALL_RELEASE_EN: forced release after STALL_LIMIT
// GRANT cycles without a transfer.
module xbar_oneout_rr_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 32,
  parameter int unsigned MAX_BURST         = 4,
  parameter int unsigned STALL_LIMIT       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  xbar_oneout_rr_arbiter_if.master  bus
);
  localparam int unsigned      IDX_W    = $clog2(N_INPUTS);
  localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  if (N_INPUTS < 2) begin : g_bad_n_inputs
    $error("N_INPUTS must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end
  if (STALL_LIMIT < 1) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be at least 1");
  end

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] grant_inc;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_last;
  logic             stall_hit;
  logic             release_c;

  rr_priority_picker #(.N_INPUTS(N_INPUTS)) u_picker (
    .req   (bus.req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign grant_inc  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
  assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));

`ifdef XBAR_ARB_STALL_RELEASE_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] stall_cnt;

  assign stall_hit = !bus.xfer && (stall_cnt == STALL_W'(STALL_LIMIT - 1));

  // Stall counter: cleared on GRANT entry and on every transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == CONFIG && bus.control_rdy) begin
      stall_cnt <= '0;
    end else if (state == GRANT) begin
      stall_cnt <= bus.xfer ? '0 : stall_cnt + STALL_W'(1);
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // A final transfer always releases by burst; otherwise drop or stall releases.
  assign release_c = bus.xfer ? burst_last : (!bus.req[grant_q] || stall_hit);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid)      state_nxt = CONFIG;
      CONFIG:  if (bus.control_rdy) state_nxt = GRANT;
      GRANT:   if (release_c)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Grant index, round-robin pointer and burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      grant_q   <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (pick_valid) grant_q <= pick_idx;
        CONFIG: if (bus.control_rdy) burst_cnt <= '0;
        GRANT: begin
          if (bus.xfer && !burst_last) burst_cnt <= burst_cnt + CNT_W'(1);
          if (release_c)               ptr       <= grant_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state; send_rdy gated off outside GRANT.
  always_comb begin
    bus.control       = '0;
    bus.control_val   = 1'b0;
    bus.xbar_send_rdy = 1'b0;
    bus.grant_active  = 1'b0;
    bus.grant_idx     = grant_q;
    case (state)
      CONFIG: begin
        bus.control_val = 1'b1;
        bus.control     = CONTROL_BIT_WIDTH'(build_control(32'(grant_q), CONTROL_BIT_WIDTH, N_INPUTS));
      end
      GRANT: begin
        bus.xbar_send_rdy = bus.sink_rdy;
        bus.grant_active  = 1'b1;
      end
      default: ;
    endcase
  end

  // A transfer outside GRANT means the crossbar ignored the gated ready.
  a_xfer_only_in_grant: assert property (@(posedge clk) disable iff (reset)
    bus.xfer |-> (state == GRANT));

endmodule
